// File: rtl/cu_seq.sv
// ---------------------------------------------------------------------------
// cu_seq : multi-cycle control sequencer for the t5 accumulator CPU
//
// Steps the CPU through fetch / decode / execute. It reads the decoded op
// byte held in the instruction register and the accumulator sign bit. It
// drives one-cycle strobes and select lines to the PC, the IR and the
// accumulator/ALU. It talks to memory with a req/ack handshake.
//
// Parameters
//   ACK_TIMEOUT : max cycles a memory request may wait for mem_ack
//   CNT_W       : width of the retired-instruction counter
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : leave IDLE and begin fetching
//   op[7:0]     : IR opcode byte, [7:5] class, [4:0] long sub-op
//   acc_neg     : accumulator bit 7 (branch condition)
//   mem_ack     : single-cycle completion pulse for the current request
//   mem_rd/wr   : memory request lines, held through the ack cycle
//   addr_sel    : 0 = PC addresses memory, 1 = IR address field
//   ir_load     : latch memory data into the IR
//   pc_inc      : PC <= PC + 1
//   pc_load     : PC <= address field
//   acc_load    : accumulator <= ALU result
//   alu_op[1:0] : 00 pass memory data, 01 add, 10 clear
//   halted      : sequencer is parked in HALT
//   fault       : sticky; illegal opcode or memory ack timeout
//   instr_cnt   : retired instruction count, wraps silently
// ---------------------------------------------------------------------------
module cu_seq #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic             acc_neg,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  // The wait counter only has to count up to ACK_TIMEOUT-1: the request
  // state is left on the cycle the count would reach ACK_TIMEOUT.
  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  // Sequencer states, 3-bit encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOADIR = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_RD     = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_WR     = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  // Instruction classes in op[7:5], matching the t5 define.v macros.
  // Classes 3'b101 and 3'b110 are unassigned and trap as illegal.
  localparam logic [2:0] CU_LDA        = 3'b000;
  localparam logic [2:0] CU_ADD        = 3'b001;
  localparam logic [2:0] CU_STA        = 3'b010;
  localparam logic [2:0] CU_JMP        = 3'b011;
  localparam logic [2:0] CU_BAN        = 3'b100;
  localparam logic [2:0] CU_LONG_BEGIN = 3'b111;

  // Sub-ops of the long class in op[4:0]
  localparam logic [4:0] SUB_NOP  = 5'd0;
  localparam logic [4:0] SUB_HALT = 5'd1;
  localparam logic [4:0] SUB_CLR  = 5'd2;

  // ALU function codes
  localparam logic [1:0] ALU_PASS  = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_CLEAR = 2'b10;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req_state;
  logic              timeout;
  logic              retire;
  logic              set_fault;

  logic [2:0] op_class;
  logic [4:0] op_sub;
  logic       long_nop;
  logic       long_halt;
  logic       long_clr;

  assign op_class  = op[7:5];
  assign op_sub    = op[4:0];
  assign long_nop  = (op_class == CU_LONG_BEGIN) && (op_sub == SUB_NOP);
  assign long_halt = (op_class == CU_LONG_BEGIN) && (op_sub == SUB_HALT);
  assign long_clr  = (op_class == CU_LONG_BEGIN) && (op_sub == SUB_CLR);

  // States that hold a memory request open and are guarded by the timeout
  assign req_state = (state == S_FETCH) || (state == S_RD) || (state == S_WR);

  // An ack on the last allowed cycle takes priority over the timeout
  assign timeout = req_state && !mem_ack && (wait_cnt == WAIT_LAST);

  // Next-state, retire and fault decisions
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    set_fault  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_next = S_LOADIR;
        end else if (timeout) begin
          state_next = S_HALT;
          set_fault  = 1'b1;
        end
      end
      S_LOADIR: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (op_class)
          CU_LDA, CU_ADD: state_next = S_RD;
          CU_STA:         state_next = S_WR;
          CU_JMP, CU_BAN: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          CU_LONG_BEGIN: begin
            if (long_nop || long_clr) begin
              retire     = 1'b1;
              state_next = S_FETCH;
            end else if (long_halt) begin
              retire     = 1'b1;
              state_next = S_HALT;
            end else begin
              set_fault  = 1'b1;
              state_next = S_HALT;
            end
          end
          default: begin
            set_fault  = 1'b1;
            state_next = S_HALT;
          end
        endcase
      end
      S_RD: begin
        if (mem_ack) begin
          state_next = S_WB;
        end else if (timeout) begin
          state_next = S_HALT;
          set_fault  = 1'b1;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_WR: begin
        if (mem_ack) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_HALT;
          set_fault  = 1'b1;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Wait counter. Every way into a request state is a state change, so
  // clearing on any change gives a fresh count for each new request. A
  // request state is only left by a change, so the count never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (req_state && !mem_ack) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Retired instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault <= 1'b0;
    else if (set_fault) fault <= 1'b1;
  end

  // Outputs decode from the registered state, so all of them fall to 0 as
  // soon as reset forces IDLE. op and acc_neg only qualify DECODE and WB.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
      end
      S_LOADIR: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_DECODE: begin
        if (op_class == CU_JMP) pc_load = 1'b1;
        if (op_class == CU_BAN) pc_load = acc_neg;
        if (long_clr) begin
          acc_load = 1'b1;
          alu_op   = ALU_CLEAR;
        end
      end
      S_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
      end
      S_WB: begin
        acc_load = 1'b1;
        alu_op   = (op_class == CU_ADD) ? ALU_ADD : ALU_PASS;
      end
      S_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cu_seq.sv
// ---------------------------------------------------------------------------
// tb_cu_seq : self-checking bench for cu_seq
//
// A memory/IR responder feeds opcodes from a program queue whenever the DUT
// loads the IR. For each opcode it pushes the execute action it should
// cause onto a scoreboard queue. Action cycles seen on the DUT outputs are
// then popped and compared. Per-kind ack delays model slow memory.
// ---------------------------------------------------------------------------
module tb_cu_seq;

  localparam int ACK_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam logic [7:0] OP_LDA  = 8'h05;
  localparam logic [7:0] OP_ADD  = 8'h26;
  localparam logic [7:0] OP_STA  = 8'h47;
  localparam logic [7:0] OP_JMP  = 8'h63;
  localparam logic [7:0] OP_BAN  = 8'h80;
  localparam logic [7:0] OP_NOP  = 8'hE0;
  localparam logic [7:0] OP_HALT = 8'hE1;
  localparam logic [7:0] OP_CLR  = 8'hE2;
  localparam logic [7:0] OP_ILL  = 8'hA0;
  localparam logic [7:0] OP_BSUB = 8'hFF;

  typedef struct {
    logic [7:0] op;
    logic       neg;
  } instr_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       op;
  logic             acc_neg;
  logic             mem_ack;
  logic             mem_rd;
  logic             mem_wr;
  logic             addr_sel;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             acc_load;
  logic [1:0]       alu_op;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_cnt;

  int         checks;
  int         errors;
  instr_t     prog[$];
  logic [5:0] exp_q[$];
  logic [3:0] exp_cnt;
  int         rd_delay;
  int         wr_delay;
  int         cycles;

  cu_seq #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .acc_neg  (acc_neg),
    .mem_ack  (mem_ack),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .addr_sel (addr_sel),
    .ir_load  (ir_load),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .acc_load (acc_load),
    .alu_op   (alu_op),
    .halted   (halted),
    .fault    (fault),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Memory / IR responder and scoreboard monitor. The ack decision is made
  // first so that the monitor sees this cycle's ack.
  initial begin
    int         ws;
    int         dly;
    logic [5:0] act;
    logic [5:0] e;
    instr_t     ins;
    mem_ack = 1'b0;
    op      = OP_NOP;
    acc_neg = 1'b0;
    ws      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        ws      = 0;
      end else begin
        if (mem_rd || mem_wr) begin
          dly = mem_wr ? wr_delay : (addr_sel ? rd_delay : 0);
          if (ws == dly) begin
            mem_ack = 1'b1;
            ws      = 0;
          end else begin
            mem_ack = 1'b0;
            ws++;
          end
        end else begin
          mem_ack = 1'b0;
          ws      = 0;
        end

        if (acc_load || pc_load || (mem_wr && mem_ack)) begin
          act = {acc_load, alu_op, pc_load, mem_wr, addr_sel};
          if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected", 32'(act), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_action", 32'(act), 32'(e));
          end
        end

        if (ir_load) begin
          if (prog.size() == 0) begin
            op      = OP_HALT;
            acc_neg = 1'b0;
          end else begin
            ins     = prog.pop_front();
            op      = ins.op;
            acc_neg = ins.neg;
            unique case (ins.op[7:5])
              3'b000: begin exp_q.push_back(6'b100000); exp_cnt++; end
              3'b001: begin exp_q.push_back(6'b101000); exp_cnt++; end
              3'b010: begin exp_q.push_back(6'b000011); exp_cnt++; end
              3'b011: begin exp_q.push_back(6'b000100); exp_cnt++; end
              3'b100: begin
                if (ins.neg) exp_q.push_back(6'b000100);
                exp_cnt++;
              end
              3'b111: begin
                if (ins.op[4:0] == 5'd2) exp_q.push_back(6'b110000);
                if (ins.op[4:0] <= 5'd2) exp_cnt++;
              end
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

  function automatic logic [10:0] allOuts();
    return {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load,
            acc_load, alu_op, halted, fault};
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    prog.delete();
    exp_q.delete();
    exp_cnt  = '0;
    rd_delay = 0;
    wr_delay = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_outs", 32'(allOuts()), 32'd0);
    checkOutput("rst_cnt", 32'(instr_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pushInstr(input logic [7:0] o, input logic n);
    instr_t i;
    i.op  = o;
    i.neg = n;
    prog.push_back(i);
  endtask

  // Pulse start, then count cycles from FETCH entry until halted, bounded
  task automatic applyStimulus(input int max_cycles, output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!halted) checkOutput("halt_wait", 32'd0, 32'd1);
  endtask

  task automatic checkEnd(input string tag, input logic exp_fault);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
    checkOutput({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    checkOutput({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt));
    checkOutput({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    rst_n  = 1'b0;
    rd_delay = 0;
    wr_delay = 0;
    exp_cnt  = '0;

    // Reset state and idle without start
    doReset();
    repeat (3) @(negedge clk);
    checkOutput("idle_outs", 32'(allOuts()), 32'd0);

    // lda / add / sta / HALT with zero-wait memory
    pushInstr(OP_LDA, 1'b0);
    pushInstr(OP_ADD, 1'b0);
    pushInstr(OP_STA, 1'b0);
    pushInstr(OP_HALT, 1'b0);
    applyStimulus(300, cycles);
    checkOutput("prog1_latency", 32'(cycles), 32'(5 + 5 + 4 + 3 + 1));
    checkEnd("prog1", 1'b0);

    // Branches not taken / taken, jmp, CLR, NOP, HALT
    doReset();
    pushInstr(OP_BAN, 1'b0);
    pushInstr(OP_BAN, 1'b1);
    pushInstr(OP_JMP, 1'b0);
    pushInstr(OP_CLR, 1'b0);
    pushInstr(OP_NOP, 1'b0);
    pushInstr(OP_HALT, 1'b0);
    applyStimulus(300, cycles);
    checkOutput("prog2_latency", 32'(cycles), 32'(6 * 3 + 1));
    checkEnd("prog2", 1'b0);
    checkOutput("prog2_cnt_abs", 32'(instr_cnt), 32'd6);

    // Illegal class after a retiring lda, then start is ignored in HALT
    doReset();
    pushInstr(OP_LDA, 1'b0);
    pushInstr(OP_ILL, 1'b0);
    applyStimulus(300, cycles);
    checkEnd("illegal_class", 1'b1);
    repeat (3) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    checkOutput("halt_sticky_outs", 32'(allOuts()), 32'b00000000011);
    checkOutput("halt_sticky_cnt", 32'(instr_cnt), 32'd1);

    // Illegal long sub-op
    doReset();
    pushInstr(OP_BSUB, 1'b0);
    applyStimulus(300, cycles);
    checkEnd("illegal_sub", 1'b1);

    // Read ack withheld: fault on the ACK_TIMEOUT-th wait cycle
    doReset();
    rd_delay = 100;
    pushInstr(OP_LDA, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_rd && addr_sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (mem_rd && addr_sel && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("to_rd_cycles", 32'(n), 32'(ACK_TIMEOUT));
    checkOutput("to_fault", 32'(fault), 32'd1);
    checkOutput("to_halted", 32'(halted), 32'd1);
    checkOutput("to_cnt", 32'(instr_cnt), 32'd0);

    // Ack on exactly the last allowed cycle wins over the timeout
    doReset();
    rd_delay = ACK_TIMEOUT - 1;
    pushInstr(OP_LDA, 1'b0);
    pushInstr(OP_HALT, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_rd && addr_sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (mem_rd && addr_sel && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("late_ack_rd_cycles", 32'(n), 32'(ACK_TIMEOUT));
    checkOutput("late_ack_wb", 32'({acc_load, alu_op}), 32'b100);
    n = 0;
    while (!halted && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkEnd("late_ack", 1'b0);

    // Reset in the middle of a write: request drops asynchronously
    doReset();
    wr_delay = 100;
    pushInstr(OP_STA, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("midwr_before", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midwr_async_drop", 32'(mem_wr), 32'd0);
    checkOutput("midwr_outs", 32'(allOuts()), 32'd0);
    prog.delete();
    exp_q.delete();
    exp_cnt = '0;
    wr_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midwr_idle_outs", 32'(allOuts()), 32'd0);
    checkOutput("midwr_cnt", 32'(instr_cnt), 32'd0);

    // Sixteen retirements wrap the 4-bit counter back to zero
    doReset();
    for (int i = 0; i < 15; i++) pushInstr(OP_NOP, 1'b0);
    pushInstr(OP_HALT, 1'b0);
    applyStimulus(400, cycles);
    checkEnd("wrap", 1'b0);
    checkOutput("wrap_zero", 32'(instr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
- Multi-cycle control sequencer for the t5 accumulator CPU.
- Drives fetch/decode/execute around the instruction register decoder (ir), program counter, memory and accumulator/ALU.
- Consumes the decoded op byte from the instruction register and the accumulator sign bit.
- Issues one-cycle strobes and select lines, and handshakes with memory via req/ack.
- Counts retired instructions and traps illegal opcodes and memory timeouts.

Parameters:
- ACK_TIMEOUT, 15: max cycles a memory request waits for mem_ack before fault.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching
- op  in  8  decoded opcode byte from instruction register; [7:5] = class, [4:0] = long sub-op
- acc_neg  in  1  accumulator bit 7
- mem_ack  in  1  memory completion for current req, single-cycle pulse
- mem_rd  out  1  memory read request, held until ack
- mem_wr  out  1  memory write request, held until ack
- addr_sel  out  1  0 = PC drives memory address, 1 = ir ad field
- ir_load  out  1  latch memory data into instruction register
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= ad
- acc_load  out  1  accumulator <= ALU result
- alu_op  out  2  00 pass mem data, 01 add, 10 clear
- halted  out  1  in HALT state
- fault  out  1  sticky; illegal opcode or ack timeout
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n low): state = IDLE; wait_cnt = 0; instr_cnt = 0; fault = 0.
- Outputs are combinational from the registered state plus op/acc_neg. All strobes are 0 in IDLE and HALT, so every output is 0 during reset.
- A mid-operation reset abandons any request immediately; mem_rd/mem_wr drop asynchronously.
- States: IDLE, FETCH, LOADIR, DECODE, RD, WB, WR, HALT (3-bit encoding).
- IDLE: wait for start=1, then go to FETCH.
- FETCH: mem_rd=1, addr_sel=0. On mem_ack go to LOADIR.
- LOADIR: ir_load=1, pc_inc=1, one cycle, then DECODE.
- DECODE (one cycle, op settled), dispatch on op[7:5] using the define.v macros:
  - cu_add, cu_lda: go to RD.
  - cu_sta: go to WR.
  - cu_jmp: pc_load=1, retire, go to FETCH.
  - cu_ban: pc_load=acc_neg, retire, go to FETCH. A not-taken branch still retires.
  - cu_long_begin, op[4:0]=0 (NOP): retire, go to FETCH.
  - cu_long_begin, op[4:0]=1 (HALT): retire, go to HALT.
  - cu_long_begin, op[4:0]=2 (CLR): acc_load=1, alu_op=10, retire, go to FETCH.
  - Any other sub-op, or an unlisted class: fault=1, go to HALT, no retire.
- RD: mem_rd=1, addr_sel=1. On mem_ack go to WB.
- WB: acc_load=1; alu_op=01 for add, 00 for lda. Retire, go to FETCH.
- WR: mem_wr=1, addr_sel=1. On mem_ack, retire, go to FETCH.
- Retire: instr_cnt += 1 on the clock edge leaving the retiring state. Wraps at 2^CNT_W-1 to 0 with no flag.
- wait_cnt:
  - Clears on entry to FETCH, RD or WR.
  - Increments each cycle in those states while mem_ack=0.
  - If it reaches ACK_TIMEOUT with no ack: fault=1, go to HALT. An ack arriving on that same cycle wins; no fault.
- mem_ack outside FETCH/RD/WR is ignored.
- A request line stays asserted through the ack cycle and deasserts the next cycle.
- HALT is terminal until reset; start is ignored there.
- Latencies with zero-wait memory (ack in first request cycle), from FETCH entry:
  - jmp/ban/NOP/CLR: 3 cycles.
  - add/lda: 5 cycles.
  - sta: 4 cycles.

Test Plan:
- Reset then start; memory returns lda 5, add 6, sta 7, HALT with ack every request cycle -> acc_load pulses with alu_op 00 then 01; mem_wr with addr_sel=1; halted=1; instr_cnt=4; fault=0.
- ban with acc_neg=0, then ban with acc_neg=1 -> pc_load 0 then 1 in DECODE; both retire (instr_cnt +2).
- Illegal class 3'b101, and cu_long_begin with sub-op 5'h1F -> fault=1, halted=1, instr_cnt unchanged; start pulses afterwards have no effect.
- Withhold mem_ack in RD for ACK_TIMEOUT cycles -> fault on the ACK_TIMEOUT-th wait cycle. Repeat with ack on exactly that cycle -> no fault, proceed to WB.
- Assert rst_n=0 mid-WR with mem_wr high -> mem_wr drops immediately; after release state is IDLE, all outputs 0, instr_cnt=0.
- Preload instr_cnt path with CNT_W=4 and run 16 NOPs -> instr_cnt wraps to 0.
